// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - execute-stage divider request/result bundle
interface div_unit_if;
  logic        div_validE;
  logic        signed_divE;
  logic [31:0] a;
  logic [31:0] b;
  logic        hold;
  logic        cancel;
  logic        div_stall;
  logic        div_ready;
  logic [63:0] result;

  modport master (
    output div_validE, signed_divE, a, b, hold, cancel,
    input  div_stall, div_ready, result
  );

  modport slave (
    input  div_validE, signed_divE, a, b, hold, cancel,
    output div_stall, div_ready, result
  );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-bit radix-2 restoring divider, result = {remainder, quotient}
// Optional DIV_FAST_EN: trivial cases (b = 0 or |b| > |a|) finish straight from IDLE.
module div_unit (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_n;
  logic [5:0]  cnt;
  logic [31:0] rem, quo, mag_b, a_raw;
  logic        neg_q, neg_r, b_zero;

  logic [31:0] a_mag, b_mag;
  logic        fast;
  logic [63:0] fast_result;
  logic [32:0] rem_sh, diff;
  logic [31:0] rem_n, quo_n, q_fix, r_fix;

  always_comb begin
    a_mag = (bus.signed_divE && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
    b_mag = (bus.signed_divE && bus.b[31]) ? (32'd0 - bus.b) : bus.b;
`ifdef DIV_FAST_EN
    fast = (b_mag == 32'd0) || (b_mag > a_mag);
`else
    fast = 1'b0;
`endif
    fast_result = {bus.a, (bus.b == 32'd0) ? 32'hFFFF_FFFF : 32'h0};
  end

  // One restoring step: the bit shifted out of quo enters rem, 33 bits wide so it is never lost
  always_comb begin
    rem_sh = {rem, quo[31]};
    diff   = rem_sh - {1'b0, mag_b};
    if (!diff[32]) begin
      rem_n = diff[31:0];
      quo_n = {quo[30:0], 1'b1};
    end else begin
      rem_n = rem_sh[31:0];
      quo_n = {quo[30:0], 1'b0};
    end
    q_fix = b_zero ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - quo_n) : quo_n);
    r_fix = b_zero ? a_raw         : (neg_r ? (32'd0 - rem_n) : rem_n);
  end

  always_comb begin
    state_n = state;
    if (bus.cancel) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.div_validE) state_n = fast ? DONE : BUSY;
        BUSY:    if (cnt == 6'd31)   state_n = DONE;
        DONE:    if (!bus.hold)      state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
    bus.div_stall = rst & bus.div_validE & ~bus.cancel & (state != DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= 6'd0;
      rem           <= 32'd0;
      quo           <= 32'd0;
      mag_b         <= 32'd0;
      a_raw         <= 32'd0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      b_zero        <= 1'b0;
      bus.result    <= 64'd0;
      bus.div_ready <= 1'b0;
    end else begin
      state         <= state_n;
      bus.div_ready <= (state_n == DONE);
      if (state == IDLE && state_n == BUSY) begin
        cnt    <= 6'd0;
        rem    <= 32'd0;
        quo    <= a_mag;
        mag_b  <= b_mag;
        a_raw  <= bus.a;
        neg_q  <= bus.signed_divE & (bus.a[31] ^ bus.b[31]);
        neg_r  <= bus.signed_divE & bus.a[31];
        b_zero <= (bus.b == 32'd0);
      end else if (state == BUSY) begin
        cnt <= cnt + 6'd1;
        rem <= rem_n;
        quo <= quo_n;
      end
      if (state == BUSY && state_n == DONE)
        bus.result <= {r_fix, q_fix};
      if (state == IDLE && state_n == DONE)
        bus.result <= fast_result;
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - vector, random and corner-sequence bench for div_unit
module tb_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  div_unit_if bus();
  div_unit dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          sg;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [63:0] last_res;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sg);
    longint la, lb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sg) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
    end else begin
      la = longint'({32'd0, a});
      lb = longint'({32'd0, b});
    end
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input bit sg);
`ifdef DIV_FAST_EN
    longint ma, mb;
    ma = sg ? longint'($signed(a)) : longint'({32'd0, a});
    mb = sg ? longint'($signed(b)) : longint'({32'd0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (mb == 0 || mb > ma) return 1;
`endif
    return 33;
  endfunction

  // Precondition: just after a rising edge, block idle
  task automatic do_div(input logic [31:0] ta, input logic [31:0] tb_b, input bit sg,
                        input logic [63:0] exp, input string nm);
    int lat, stall_cnt, ready_at;
    logic [63:0] res;
    lat = ref_lat(ta, tb_b, sg);
    stall_cnt = 0;
    ready_at = 0;
    res = 'x;
    bus.a = ta; bus.b = tb_b; bus.signed_divE = sg; bus.div_validE = 1'b1;
    for (int n = 0; n < 100 && ready_at == 0; n++) begin
      @(negedge clk);
      if (bus.div_stall) stall_cnt++;
      if (bus.div_ready) begin
        ready_at = n;
        res = bus.result;
      end
      @(posedge clk); #1;
    end
    bus.div_validE = 1'b0;
    chk({nm, " ready_at"}, 64'(ready_at), 64'(lat));
    chk({nm, " stall_cycles"}, 64'(stall_cnt), 64'(lat));
    chk({nm, " result"}, res, exp);
    last_res = exp;
  endtask

  initial begin
    bus.div_validE = 1'b1; bus.signed_divE = 1'b0;
    bus.a = 32'd100; bus.b = 32'd7; bus.hold = 1'b0; bus.cancel = 1'b0;
    last_res = 64'd0;

    vecs.push_back('{32'd100,        32'd7,          1'b0, {32'h0000_0002, 32'h0000_000E}});
    vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}});
    vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'h0000_0000, 32'h8000_0000}});
    vecs.push_back('{32'h1234_5678,  32'd0,          1'b0, {32'h1234_5678, 32'hFFFF_FFFF}});
    vecs.push_back('{32'hFFFF_FFF0,  32'd0,          1'b1, {32'hFFFF_FFF0, 32'hFFFF_FFFF}});
    vecs.push_back('{32'd7,          32'hFFFF_FFFE,  1'b1, {32'h0000_0001, 32'hFFFF_FFFD}});
    vecs.push_back('{32'hFFFF_FFFF,  32'd1,          1'b0, {32'h0000_0000, 32'hFFFF_FFFF}});
    vecs.push_back('{32'd5,          32'd10,         1'b0, {32'h0000_0005, 32'h0000_0000}});
    vecs.push_back('{32'h8000_0000,  32'h8000_0000,  1'b1, {32'h0000_0000, 32'h0000_0001}});

    // Reset state, with a request pending to show stall is masked
    #2;
    chk("reset div_stall", 64'(bus.div_stall), 64'd0);
    chk("reset div_ready", 64'(bus.div_ready), 64'd0);
    chk("reset result", bus.result, 64'd0);
    bus.div_validE = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      do_div(vecs[i].a, vecs[i].b, vecs[i].sg, vecs[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 25; i++) begin
      logic [31:0] ra, rb;
      bit rs;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if ($urandom_range(0, 4) == 0) ra = 32'($urandom_range(0, 20));
      rs = 1'($urandom_range(0, 1));
      do_div(ra, rb, rs, ref_div(ra, rb, rs), $sformatf("rnd%0d", i));
    end

    // Cancel while counter = 10 (cycle T+11)
    begin
      int seen_ready = 0;
      bus.a = 32'd1000; bus.b = 32'd3; bus.signed_divE = 1'b0; bus.div_validE = 1'b1;
      repeat (11) begin @(posedge clk); #1; end
      bus.cancel = 1'b1;
      #1;
      chk("cancel drops stall", 64'(bus.div_stall), 64'd0);
      @(posedge clk); #1;
      bus.cancel = 1'b0; bus.div_validE = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (bus.div_ready) seen_ready++;
      end
      chk("cancel no ready", 64'(seen_ready), 64'd0);
      chk("cancel keeps result", bus.result, last_res);
      @(posedge clk); #1;
    end

    // Hold keeps a finished result presented for 5 cycles
    begin
      int ready_cnt = 0, same_cnt = 0;
      bus.a = 32'd100; bus.b = 32'd7; bus.signed_divE = 1'b0;
      bus.hold = 1'b1; bus.div_validE = 1'b1;
      repeat (ref_lat(32'd100, 32'd7, 1'b0)) begin @(posedge clk); #1; end
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (bus.div_ready) ready_cnt++;
        if (bus.result === {32'h0000_0002, 32'h0000_000E}) same_cnt++;
        if (k == 4) bus.hold = 1'b0;
        @(posedge clk); #1;
      end
      bus.div_validE = 1'b0;
      chk("hold ready cycles", 64'(ready_cnt), 64'd5);
      chk("hold result stable", 64'(same_cnt), 64'd5);
      @(negedge clk);
      chk("hold released idle", 64'(bus.div_ready), 64'd0);
      @(posedge clk); #1;
    end

    // Asynchronous reset at T+15
    begin
      bus.a = 32'd1000; bus.b = 32'd3; bus.signed_divE = 1'b0; bus.div_validE = 1'b1;
      repeat (15) begin @(posedge clk); #1; end
      rst = 1'b0;
      #1;
      chk("midrst stall", 64'(bus.div_stall), 64'd0);
      chk("midrst ready", 64'(bus.div_ready), 64'd0);
      chk("midrst result", bus.result, 64'd0);
      bus.div_validE = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      do_div(32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E}, "after_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the execute stage. Started by the decoded `div_validE`/`signed_divE` controls, it stalls the pipeline while it runs a radix-2 restoring division. It then presents `{remainder, quotient}` for the HI/LO write that the control pipeline carries to writeback. It signals the hazard unit through `div_stall` and takes exception flushes through `cancel`.

## Interface
- No parameters. Width is fixed at 32.
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `div_validE` in 1: division request from the execute-stage control pipeline; held high while the E stage is stalled.
- `signed_divE` in 1: 1 = DIV (two's complement), 0 = DIVU.
- `a` in 32: dividend (rs value after forwarding).
- `b` in 32: divisor (rt value after forwarding).
- `hold` in 1: E stage held by a non-divider source (e.g. memory stall); keeps a finished result presented.
- `cancel` in 1: flush of E (exception or eret); aborts any operation.
- `div_stall` out 1: combinational; request stall of F/D/E.
- `div_ready` out 1: registered; result valid this cycle.
- `result` out 64: registered; `[63:32]` = remainder (HI), `[31:0]` = quotient (LO).

## Operation
- States:
  - IDLE: `div_ready`=0.
  - BUSY: 32 iterations; 6-bit counter.
  - DONE: `div_ready`=1.
- IDLE -> BUSY when `div_validE & ~cancel`. Operand magnitudes, sign flags and op type are latched on that edge, so later changes on `a`/`b` are ignored.
- Magnitudes: signed op uses |a|, |b| as 32-bit unsigned; 0x80000000 maps to 2^31 exactly. Unsigned op uses the raw values.
- Each BUSY cycle shifts `{rem, quo}` left 1. The trial subtraction uses a 33-bit `rem - |b|`; if the result is non-negative, `rem` is replaced and the quotient bit is set to 1.
- On counter = 31, BUSY -> DONE. The sign fixup is registered into `result` on the same edge:
  - quotient negated iff signed and sign(a) != sign(b);
  - remainder negated iff signed and a negative.
- Divide by zero: `result` = {a, 0xFFFFFFFF}. No exception and no extra latency; the algorithm yields this naturally, and the fixup is suppressed for b = 0.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- DONE -> IDLE when `hold`=0. DONE stays DONE while `hold`=1, with `result` and `div_ready` stable.
- `div_stall` = `div_validE & ~cancel & (state != DONE)`. It is forced to 0 while `rst` is low.
- `cancel` in any state -> IDLE on the next edge. `div_ready` is not asserted and `result` is not updated. `cancel` has priority over start and completion.

## Timing
- Reset values: state IDLE, counter 0, `result` 0, `div_ready` 0, `div_stall` 0.
- Start sampled at edge T (state IDLE, `div_validE`=1). BUSY spans cycles T+1..T+32 and DONE is cycle T+33.
- `div_stall` is high in cycles T..T+32 (33 cycles) and low in T+33, so the divide instruction advances to M at the end of T+33 if `hold`=0.
- `result` is valid exactly while `div_ready`=1, and holds its value after DONE until the next completion.
- A new request arriving in the cycle DONE exits (next instruction in E) starts only when the state is IDLE, i.e. one cycle later. `div_stall` covers that cycle.
- Reset asserted mid-operation returns the block to its reset values immediately (asynchronous); no partial result is kept.

## Configuration
- `DIV_FAST_EN` defined: in IDLE, if b = 0 or |b| > |a| (after magnitude conversion), the block goes IDLE -> DONE directly.
  - `result` = {a, 0xFFFFFFFF} for b = 0, else {a, 0}.
  - Stall lasts 1 cycle (T) and `div_ready` is high at T+1.
- `DIV_FAST_EN` undefined: every operation takes the full 32-iteration path (33 stall cycles).

## Test plan
- DIVU 100 / 7 at T -> `div_stall` high T..T+32, `div_ready` at T+33, `result` = {0x00000002, 0x0000000E}.
- DIV 0xFFFFFFF9 (-7) / 2 -> `result` = {0xFFFFFFFF, 0xFFFFFFFD}. DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
- DIVU 0x12345678 / 0 -> `result` = {0x12345678, 0xFFFFFFFF}, no exception. With `DIV_FAST_EN` defined, `div_ready` at T+1.
- `cancel` pulsed at counter = 10 -> IDLE next cycle, `div_ready` never asserts, `result` keeps its previous value, `div_stall` drops with `cancel`.
- `hold`=1 for 5 cycles from T+33 -> `div_ready`=1 and `result` constant for all 5 cycles, IDLE after `hold` falls. Also check `rst` low at T+15 -> all outputs 0 immediately.
